// File: rtl/lru_victim_select.sv
// rtl/lru_victim_select.sv - per-set LRU counter owner with miss victim scan
//
// Holds SETS x WAY LRU counters (WAY-1 = MRU, 0 = LRU). Hits touch a way
// directly from IDLE; a miss scans the set one way per cycle, reports the
// lowest-index invalid way (else the LRU way) and promotes it to MRU once
// the consumer commits the fill.
//
// Ports:
//   i_clk, i_rst_n                     clock, synchronous active-low reset
//   i_touch_valid/o_touch_ready        hit touch handshake
//   i_touch_set, i_touch_way           set/way of the hit
//   i_req_valid/o_req_ready            miss request handshake
//   i_req_set, i_req_vmask             set of the miss and its way valid bits
//   o_victim_valid/i_victim_ready      victim result handshake (fill commit)
//   o_victim_way, o_victim_was_invalid chosen way and why it was chosen
//   o_busy                             FSM away from IDLE
module lru_victim_select #(
  parameter  int WAY      = 4,
  parameter  int SETS     = 16,
  localparam int LRU_BITS = $clog2(WAY),
  localparam int SET_BITS = $clog2(SETS)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_touch_valid,
  output logic                o_touch_ready,
  input  logic [SET_BITS-1:0] i_touch_set,
  input  logic [LRU_BITS-1:0] i_touch_way,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [SET_BITS-1:0] i_req_set,
  input  logic [WAY-1:0]      i_req_vmask,
  output logic                o_victim_valid,
  input  logic                i_victim_ready,
  output logic [LRU_BITS-1:0] o_victim_way,
  output logic                o_victim_was_invalid,
  output logic                o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP, S_UPDATE} state_t;

  state_t state_q, state_d;

  logic [LRU_BITS-1:0] lru_q [SETS][WAY];

  logic [SET_BITS-1:0] req_set_q;
  logic [WAY-1:0]      vmask_q;
  logic [LRU_BITS-1:0] scan_idx_q;
  logic                inv_found_q;
  logic [LRU_BITS-1:0] inv_way_q;
  logic [LRU_BITS-1:0] lru_way_q;
  logic [LRU_BITS-1:0] victim_way_q;
  logic                victim_inv_q;

  logic                touch_fire, req_fire;
  logic                scan_last, scan_invalid, scan_lru;
  logic                inv_found_d;
  logic [LRU_BITS-1:0] inv_way_d, lru_way_d;
  logic                upd_en;
  logic [SET_BITS-1:0] upd_set;
  logic [LRU_BITS-1:0] upd_way, upd_old;

  // Touches win over requests in IDLE; nothing is accepted elsewhere.
  assign touch_fire = (state_q == S_IDLE) && i_touch_valid;
  assign req_fire   = (state_q == S_IDLE) && !i_touch_valid && i_req_valid;

  assign scan_last    = (scan_idx_q == LRU_BITS'(WAY - 1));
  assign scan_invalid = !vmask_q[scan_idx_q] && !inv_found_q;
  assign scan_lru     = (lru_q[req_set_q][scan_idx_q] == '0);
  assign inv_found_d  = inv_found_q || scan_invalid;
  assign inv_way_d    = scan_invalid ? scan_idx_q : inv_way_q;
  // lru_way_q starts at 0, so a set with no zero counter falls back to way 0.
  assign lru_way_d    = scan_lru ? scan_idx_q : lru_way_q;

  // One touch port into storage, shared by hits and victim promotion.
  assign upd_en  = touch_fire || (state_q == S_UPDATE);
  assign upd_set = touch_fire ? i_touch_set : req_set_q;
  assign upd_way = touch_fire ? i_touch_way : victim_way_q;
  assign upd_old = lru_q[upd_set][upd_way];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_fire) state_d = S_SCAN;
      S_SCAN:   if (scan_last) state_d = S_RESP;
      S_RESP:   if (i_victim_ready) state_d = S_UPDATE;
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAY; w++) begin
          lru_q[s][w] <= LRU_BITS'(w);
        end
      end
    end else if (upd_en) begin
      for (int w = 0; w < WAY; w++) begin
        if (LRU_BITS'(w) == upd_way) begin
          lru_q[upd_set][w] <= LRU_BITS'(WAY - 1);
        end else if (lru_q[upd_set][w] > upd_old) begin
          lru_q[upd_set][w] <= lru_q[upd_set][w] - LRU_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      req_set_q    <= '0;
      vmask_q      <= '0;
      scan_idx_q   <= '0;
      inv_found_q  <= 1'b0;
      inv_way_q    <= '0;
      lru_way_q    <= '0;
      victim_way_q <= '0;
      victim_inv_q <= 1'b0;
    end else if (req_fire) begin
      req_set_q   <= i_req_set;
      vmask_q     <= i_req_vmask;
      scan_idx_q  <= '0;
      inv_found_q <= 1'b0;
      inv_way_q   <= '0;
      lru_way_q   <= '0;
    end else if (state_q == S_SCAN) begin
      scan_idx_q  <= scan_idx_q + LRU_BITS'(1);
      inv_found_q <= inv_found_d;
      inv_way_q   <= inv_way_d;
      lru_way_q   <= lru_way_d;
      if (scan_last) begin
        victim_way_q <= inv_found_d ? inv_way_d : lru_way_d;
        victim_inv_q <= inv_found_d;
      end
    end
  end

  assign o_touch_ready        = (state_q == S_IDLE);
  assign o_req_ready          = (state_q == S_IDLE) && !i_touch_valid;
  assign o_victim_valid       = (state_q == S_RESP);
  assign o_victim_way         = victim_way_q;
  assign o_victim_was_invalid = victim_inv_q;
  assign o_busy               = (state_q != S_IDLE);

endmodule
